fifo_axis_bridge: RTL and testbench
===================================

// Module: fifo_axis_bridge
// PURPOSE
//  Sits directly downstream of the show-ahead `fifo` and drains it through the FIFO pop port (fifo_empty / r_ready / data_out).
//  Re-times the words into an AXI-Stream master with tlast framing, for the FIR / DMA consumers.
//  A 2-entry output buffer decouples the pop from m_axis_tready, so there is no combinational tready->r_ready path.
//  Sustains 1 word/clk.
// PARAMETERS
//  WIDTH   32  data word width; must match the upstream fifo WIDTH
//  LEN_W   10  width of frame-length config and beat counter
// PORTS
//  clk            in   1      single clock, all logic on posedge
//  reset          in   1      synchronous, active-high reset
//  fifo_empty     in   1      upstream FIFO empty flag
//  fifo_data      in   WIDTH  upstream data_out; head word, valid whenever !fifo_empty
//  r_ready        out  1      pop strobe to FIFO; head word consumed at posedge when high
//  cfg_frame_len  in   LEN_W  beats per frame; sampled at first beat of each frame
//  m_axis_tvalid  out  1      output word valid
//  m_axis_tready  in   1      downstream accept
//  m_axis_tdata   out  WIDTH  output word
//  m_axis_tlast   out  1      last beat of frame
//  frame_done     out  1      1-cycle pulse on tlast handshake
//  busy           out  1      occ!=0 or beat_cnt!=0
// BEHAVIOUR
//  Reset (sync, high, has priority over all other events):
//   - occ=0, beat_cnt=0, frame_len_q=0.
//   - tvalid=0, tdata=0, tlast=0, frame_done=0, busy=0.
//   - r_ready=0 (gated by reset).
//  Reset mid-operation: buffered words and partial frame are discarded; the next pop starts a new frame.
//  Pop rule (combinational):
//   - r_ready = !reset & !fifo_empty & (occ<2).
//   - pop = r_ready; captures fifo_data at that posedge.
//  Latency: a word popped at edge N is on m_axis_tdata with tvalid=1 after edge N when occ was 0 (1 cycle).
//  Buffer: 2 entries {data, last}, strict FIFO order.
//   - occ' = occ + pop - hs, where hs = tvalid & tready.
//   - Simultaneous pop and hs at occ=1 keeps occ=1 (full throughput).
//   - At occ=2, pop is blocked even if hs happens that cycle.
//  AXI rules:
//   - tvalid = (occ!=0).
//   - While tvalid & !tready, tdata and tlast hold stable.
//   - tvalid never deasserts without a handshake.
//  Framing (evaluated at pop time; the tag is stored with the word):
//   - On a pop with beat_cnt==0: frame_len_q <= cfg_frame_len, or 1 if cfg_frame_len==0.
//   - last = (beat_cnt == eff_len-1), where eff_len is the length just latched or frame_len_q.
//   - beat_cnt <= last ? 0 : beat_cnt+1. Arithmetic is LEN_W unsigned with no overflow, since beat_cnt < eff_len.
//   - A cfg_frame_len change mid-frame takes effect at the next frame.
//  frame_done is registered, high the cycle after the tlast handshake.
//  FIFO empty mid-frame: no bubble fill. tvalid drops once the buffer drains; beat_cnt holds and resumes.
// STRUCTURE
//  Shared package soc_stream_pkg:
//   - DATA_W_DEF=32, FRAME_LEN_W_DEF=10.
//   - localparam OCC_W=2.
//  Sub-module axis_skid_buf (2-entry {data,last} buffer, occ counter, tvalid/tdata/tlast).
//  The top level holds the pop logic, beat counter, frame_len_q and frame_done.
// TESTING
//  1. Reset held 3 clk with fifo_empty=0 -> r_ready=0, tvalid=0, tdata=0, busy=0 throughout.
//  2. FIFO holds 0..9, tready=1, cfg_frame_len=4 -> tdata 0..9 on consecutive clks.
//     tlast on 3 and 7; frame_done pulses twice; 8,9 leave beat_cnt=2.
//  3. tready=0 with 5 words queued -> exactly 2 pops then r_ready=0.
//     tdata=first word held stable; release tready -> remaining 3 in order, no loss or duplication.
//  4. tready toggling 1010.. with a random FIFO fill -> scoreboard: output order == push order.
//     Never 2 pops while occ=2.
//  5. cfg_frame_len=0 -> tlast on every beat.
//     cfg_frame_len changed 4->2 at beat 1 -> current frame ends at beat 3, next frames every 2.
//  6. reset pulsed with occ=2 mid-frame -> next cycle tvalid=0.
//     The first beat after reset counts as beat 0 (cfg_frame_len=3 gives tlast on 3rd beat).

Source files
------------

// File: rtl/soc_stream_pkg.sv
// soc_stream_pkg: shared widths and types for the stream bridge blocks
package soc_stream_pkg;
    localparam int DATA_W_DEF      = 32;
    localparam int FRAME_LEN_W_DEF = 10;
    localparam int OCC_W           = 2;
    typedef logic [OCC_W-1:0] occ_t;
endpackage

// File: rtl/fifo_axis_bridge_if.sv
// fifo_axis_bridge_if: AXI-Stream data channel with master/slave views
interface fifo_axis_bridge_if import soc_stream_pkg::*; #(parameter int WIDTH = DATA_W_DEF);
    logic             tvalid;
    logic             tready;
    logic [WIDTH-1:0] tdata;
    logic             tlast;
    modport master(output tvalid, output tdata, output tlast, input tready);
    modport slave(input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axis_skid_buf.sv
// axis_skid_buf: 2-entry {data,last} output buffer driving an AXI-Stream master from registers
module axis_skid_buf import soc_stream_pkg::*; #(
    parameter int WIDTH = DATA_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push_i,
    input  logic [WIDTH-1:0]   data_i,
    input  logic               last_i,
    output occ_t               occ_o,
    fifo_axis_bridge_if.master m_axis
);
    occ_t             occ_q, occ_d, rem;
    logic [WIDTH-1:0] d0_q, d0_d, d1_q, d1_d;
    logic             l0_q, l0_d, l1_q, l1_d, hs;

    assign hs            = (occ_q != 2'd0) && m_axis.tready;
    assign m_axis.tvalid = occ_q != 2'd0;
    assign m_axis.tdata  = d0_q;
    assign m_axis.tlast  = l0_q;
    assign occ_o         = occ_q;

    // Shift the tail forward on a handshake, then drop a pushed word into the first free slot
    always_comb begin
        rem   = occ_q - occ_t'(hs);
        d0_d  = (push_i && rem == 2'd0) ? data_i : ((hs && occ_q == 2'd2) ? d1_q : d0_q);
        l0_d  = (push_i && rem == 2'd0) ? last_i : ((hs && occ_q == 2'd2) ? l1_q : l0_q);
        d1_d  = (push_i && rem == 2'd1) ? data_i : d1_q;
        l1_d  = (push_i && rem == 2'd1) ? last_i : l1_q;
        occ_d = rem + occ_t'(push_i);
    end

    // Buffer storage and occupancy; reset discards anything held
    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q <= '0;
            d0_q  <= '0;
            l0_q  <= 1'b0;
            d1_q  <= '0;
            l1_q  <= 1'b0;
        end else begin
            occ_q <= occ_d;
            d0_q  <= d0_d;
            l0_q  <= l0_d;
            d1_q  <= d1_d;
            l1_q  <= l1_d;
        end
    end
endmodule

// File: rtl/fifo_axis_bridge.sv
// fifo_axis_bridge: drains a show-ahead FIFO into a framed AXI-Stream master at 1 word/clk
module fifo_axis_bridge import soc_stream_pkg::*; #(
    parameter int WIDTH = DATA_W_DEF,
    parameter int LEN_W = FRAME_LEN_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fifo_empty,
    input  logic [WIDTH-1:0]   fifo_data,
    output logic               r_ready,
    input  logic [LEN_W-1:0]   cfg_frame_len,
    fifo_axis_bridge_if.master m_axis,
    output logic               frame_done,
    output logic               busy
);
    occ_t             occ;
    logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d, frame_len_q, frame_len_d, eff_len;
    logic             last, frame_done_q;

    // Pop depends only on registered occupancy, so tready never reaches r_ready
    assign r_ready    = !reset && !fifo_empty && (occ < 2'd2);
    assign frame_done = frame_done_q;
    assign busy       = (occ != 2'd0) || (beat_cnt_q != '0);

    // Framing tag computed at pop time; a zero length is treated as single-beat frames
    always_comb begin
        eff_len     = (beat_cnt_q == '0) ? ((cfg_frame_len == '0) ? LEN_W'(1) : cfg_frame_len) : frame_len_q;
        last        = beat_cnt_q == eff_len - LEN_W'(1);
        frame_len_d = (r_ready && beat_cnt_q == '0) ? eff_len : frame_len_q;
        beat_cnt_d  = !r_ready ? beat_cnt_q : (last ? '0 : beat_cnt_q + LEN_W'(1));
    end

    // Beat counter, latched frame length and the registered end-of-frame pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt_q   <= '0;
            frame_len_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            beat_cnt_q   <= beat_cnt_d;
            frame_len_q  <= frame_len_d;
            frame_done_q <= m_axis.tvalid && m_axis.tready && m_axis.tlast;
        end
    end

    axis_skid_buf #(.WIDTH(WIDTH)) u_buf (
        .clk    (clk),
        .reset  (reset),
        .push_i (r_ready),
        .data_i (fifo_data),
        .last_i (last),
        .occ_o  (occ),
        .m_axis (m_axis)
    );
endmodule

// File: tb/tb_fifo_axis_bridge.sv
// tb_fifo_axis_bridge: scoreboard bench for the FIFO to AXI-Stream bridge
module tb_fifo_axis_bridge;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fifo_empty = 1'b1;
    logic [31:0] fifo_data = 32'h0;
    logic        r_ready, frame_done, busy;
    logic [9:0]  cfg = 10'd4;
    logic [31:0] fq[$];
    logic [32:0] exp_q[$];
    logic [32:0] prev = '0;
    logic        force_ne = 1'b0, done_exp = 1'b0, rst_seen = 1'b1, hold = 1'b0;
    int          total = 0, bad = 0, outst = 0, hs_cnt = 0, done_cnt = 0;

    fifo_axis_bridge_if #(.WIDTH(32)) axis ();

    fifo_axis_bridge #(.WIDTH(32), .LEN_W(10)) dut (
        .clk           (clk),
        .reset         (reset),
        .fifo_empty    (fifo_empty),
        .fifo_data     (fifo_data),
        .r_ready       (r_ready),
        .cfg_frame_len (cfg),
        .m_axis        (axis),
        .frame_done    (frame_done),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic l);
        fq.push_back(d);
        exp_q.push_back({l, d});
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || fq.size() != 0) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_left", 64'(exp_q.size() + fq.size()), 0);
    endtask

    // Upstream FIFO model: pops on r_ready, occupancy bookkeeping, expected frame_done
    always @(posedge clk) begin
        rst_seen = reset;
        if (reset) begin
            outst = 0;
            exp_q.delete();
            done_exp = 1'b0;
        end else begin
            if (r_ready) begin
                chk("pop_while_full", 64'(outst < 2), 1);
                outst++;
                if (fq.size() != 0) void'(fq.pop_front());
            end
            if (axis.tvalid && axis.tready) begin
                outst--;
                hs_cnt++;
            end
            done_exp = axis.tvalid && axis.tready && axis.tlast;
        end
    end

    // Present the FIFO head away from the clock edge
    always @(negedge clk) begin
        fifo_empty = force_ne ? 1'b0 : (fq.size() == 0);
        fifo_data  = force_ne ? 32'hDEAD_BEEF : ((fq.size() != 0) ? fq[0] : 32'h0);
    end

    // Monitor: reset values, tvalid vs occupancy, stability under backpressure, beat order
    always @(negedge clk) begin
        if (reset) chk("rst_r_ready", r_ready, 0);
        if (rst_seen) begin
            chk("rst_tvalid", axis.tvalid, 0);
            chk("rst_tdata", axis.tdata, 0);
            chk("rst_tlast", axis.tlast, 0);
            chk("rst_busy", busy, 0);
            chk("rst_frame_done", frame_done, 0);
            hold = 1'b0;
        end else begin
            chk("tvalid", axis.tvalid, 64'(outst != 0));
            chk("frame_done", frame_done, done_exp);
            if (frame_done) done_cnt++;
            if (axis.tvalid && hold) chk("stable", {axis.tlast, axis.tdata}, prev);
            if (axis.tvalid && axis.tready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_beat: got %0h want none", {axis.tlast, axis.tdata});
                end else chk("beat", {axis.tlast, axis.tdata}, exp_q.pop_front());
            end
            hold = axis.tvalid && !axis.tready;
            prev = {axis.tlast, axis.tdata};
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0, d0, k;
        axis.tready = 1'b1;
        force_ne = 1'b1;
        repeat (3) @(posedge clk);
        #1 force_ne = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        h0 = hs_cnt;
        d0 = done_cnt;
        for (int i = 0; i < 10; i++) push(32'(i), i == 3 || i == 7);
        repeat (11) @(posedge clk);
        #1;
        chk("throughput", 64'(hs_cnt - h0), 10);
        chk("drained", 64'(exp_q.size()), 0);
        @(negedge clk);
        chk("busy_midframe", busy, 1);
        chk("frame_done_count", 64'(done_cnt - d0), 2);
        @(posedge clk);
        #1 axis.tready = 1'b0;
        push(32'd10, 1'b0);
        push(32'd11, 1'b1);
        push(32'd12, 1'b0);
        push(32'd13, 1'b0);
        push(32'd14, 1'b0);
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("fifo_left", 64'(fq.size()), 3);
        chk("r_ready_full", r_ready, 0);
        chk("held_tvalid", axis.tvalid, 1);
        chk("held_tdata", axis.tdata, 10);
        @(posedge clk);
        #1 axis.tready = 1'b1;
        push(32'd15, 1'b1);
        drain(40);
        cfg = 10'd5;
        begin
            int n = 0, c = 0;
            while (n < 15 && c < 400) begin
                @(posedge clk);
                #1 axis.tready = (c % 2) == 0;
                if ($urandom_range(0, 1) == 1) begin
                    push($urandom, (n % 5) == 4);
                    n++;
                end
                c++;
            end
            chk("random_pushed", 64'(n), 15);
        end
        @(posedge clk);
        #1 axis.tready = 1'b1;
        drain(60);
        cfg = 10'd0;
        for (int i = 0; i < 4; i++) push(32'hA0 + 32'(i), 1'b1);
        drain(30);
        cfg = 10'd4;
        push(32'hB0, 1'b0);
        k = 0;
        while (fq.size() != 0 && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("b0_popped", 64'(fq.size()), 0);
        cfg = 10'd2;
        push(32'hB1, 1'b0);
        push(32'hB2, 1'b0);
        push(32'hB3, 1'b1);
        push(32'hB4, 1'b0);
        push(32'hB5, 1'b1);
        push(32'hB6, 1'b0);
        push(32'hB7, 1'b1);
        drain(40);
        cfg = 10'd4;
        axis.tready = 1'b0;
        push(32'hC0, 1'b0);
        push(32'hC1, 1'b0);
        k = 0;
        while (outst != 2 && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("occ_full", 64'(outst), 2);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post_rst_tvalid", axis.tvalid, 0);
        chk("post_rst_busy", busy, 0);
        cfg = 10'd3;
        axis.tready = 1'b1;
        push(32'hD0, 1'b0);
        push(32'hD1, 1'b0);
        push(32'hD2, 1'b1);
        drain(30);
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
